counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_seq_pkg.sv | 22 ++
 rtl/count_core.sv | 22 ++
 rtl/counter_sequencer.sv | 114 +++++++++++
 tb/tb_counter_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types for counter_sequencer: FSM state enum and default counter width.
// COUNTER_SEQUENCER_PAUSE_EN adds the PAUSE state.
package counter_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

`ifdef COUNTER_SEQUENCER_PAUSE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd3
  } seq_state_t;
`endif

endpackage

// File: rtl/count_core.sv
// WIDTH-bit count register: clear has priority over increment, otherwise holds.
module count_core #(
  parameter int unsigned WIDTH = counter_seq_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop counter sequencer with one-shot or periodic terminal count.
// Define COUNTER_SEQUENCER_PAUSE_EN to add the pause input and PAUSE state.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = counter_seq_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic             periodic,
`ifdef COUNTER_SEQUENCER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [WIDTH-1:0] r_limit_q;
  logic             r_periodic_q;
  logic             r_done;
  logic             w_done_next;
  logic             w_latch;
  logic             w_clr;
  logic             w_inc;
  logic             w_at_limit;
  logic [WIDTH-1:0] w_count;

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_inc),
    .o_count (w_count)
  );

  assign w_at_limit = (w_count == r_limit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_limit_q    <= '0;
      r_periodic_q <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      if (w_latch) begin
        r_limit_q    <= limit;
        r_periodic_q <= periodic;
      end
    end
  end

  // Stop overrides everything; in RUN, pause outranks terminal-count detection.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_latch      = 1'b0;
    w_clr        = 1'b0;
    w_inc        = 1'b0;
    if (stop) begin
      w_state_next = ST_IDLE;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_next = ST_RUN;
            w_latch      = 1'b1;
            w_clr        = 1'b1;
          end
        end
        ST_RUN: begin
`ifdef COUNTER_SEQUENCER_PAUSE_EN
          if (pause) begin
            w_state_next = ST_PAUSE;
          end else
`endif
          if (w_at_limit) begin
            w_done_next = 1'b1;
            if (r_periodic_q) w_clr = 1'b1;
            else              w_state_next = ST_DONE;
          end else begin
            w_inc = 1'b1;
          end
        end
`ifdef COUNTER_SEQUENCER_PAUSE_EN
        ST_PAUSE: begin
          if (!pause) w_state_next = ST_RUN;
        end
`endif
        default: begin
          w_state_next = ST_IDLE;
          w_clr        = 1'b1;
        end
      endcase
    end
  end

`ifdef COUNTER_SEQUENCER_PAUSE_EN
  assign busy = (r_state == ST_RUN) || (r_state == ST_PAUSE);
`else
  assign busy = (r_state == ST_RUN);
`endif
  assign count = w_count;
  assign done  = r_done;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_counter_sequencer;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 1 << W;
`ifdef COUNTER_SEQUENCER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] limit = '0;
  logic         periodic = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model: "active" means counting (including while paused).
  bit          m_active;
  bit          m_paused;
  int unsigned m_count;
  int unsigned m_lim;
  bit          m_per;
  bit          m_done;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .limit    (limit),
    .periodic (periodic),
`ifdef COUNTER_SEQUENCER_PAUSE_EN
    .pause    (pause),
`endif
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_active = 0; m_paused = 0; m_count = 0; m_lim = 0; m_per = 0; m_done = 0;
  endtask

  task automatic mdl_step();
    bit d;
    d = 0;
    if (rst) begin
      mdl_reset();
      return;
    end
    if (stop) begin
      m_active = 0; m_paused = 0; m_count = 0;
    end else if (!m_active) begin
      if (start) begin
        m_lim = limit; m_per = periodic; m_count = 0; m_active = 1;
      end
    end else if (m_paused) begin
      if (!pause) m_paused = 0;
    end else if (PAUSE_EN && pause) begin
      m_paused = 1;
    end else if (m_count == m_lim) begin
      d = 1;
      if (m_per) m_count = 0;
      else       m_active = 0;
    end else begin
      m_count = (m_count + 1) % MOD;
    end
    m_done = d;
  endtask

  task automatic check_outputs();
    check("count", count, m_count);
    check("busy", busy, m_active);
    check("done", done, m_done);
  endtask

  // One clock: model advances at the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    mdl_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_start(input int unsigned lim, input bit per);
    limit = lim[W-1:0]; periodic = per; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    mdl_reset();
    #2;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // One-shot, limit 3: 0,1,2,3 then DONE holding 3
    do_start(3, 0);
    check("os_first", count, 0);
    repeat (6) tick();
    check("os_hold", count, 3);
    check("os_idle", busy, 0);

    // Periodic, limit 2
    do_start(2, 1);
    repeat (8) tick();
    check("per_busy", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Stop at count 5 with limit 9
    do_start(9, 0);
    repeat (5) tick();
    check("stop_at5", count, 5);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_cnt", count, 0);
    check("stop_done", done, 0);

    // Start together with stop in IDLE stays idle
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("ss_idle", busy, 0);

    // Limit 15 periodic: wrap with done, mid-run start ignored
    do_start(15, 1);
    for (int unsigned i = 0; i < 20; i++) begin
      start = (i >= 4 && i < 7);
      limit = 4'd1; periodic = 1'b0;
      tick();
    end
    start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    // Limit 0 one-shot: done after first run edge
    do_start(0, 0);
    tick();
    check("lim0_done", done, 1);

    if (PAUSE_EN) begin
      do_start(4, 0);
      repeat (2) tick();
      pause = 1'b1; repeat (3) tick();
      check("pause_hold", count, 2);
      pause = 1'b0; repeat (4) tick();
    end

    // Asynchronous reset mid-cycle at count 6
    do_start(9, 0);
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    mdl_reset();
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    check("arst_stay", busy, 0);
    do_start(9, 0);
    check("arst_restart", count, 0);
    tick();
    check("arst_cnt1", count, 1);

    // Random stimulus
    for (int unsigned i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 40) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      periodic = $urandom_range(0, 1);
      limit    = ($urandom_range(0, 3) == 0) ? W'(MOD - 1) : W'($urandom_range(0, 9));
      if ($urandom_range(0, 400) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
